// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response channel used by the fetch stage.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, one outstanding imem request,
// single-entry output buffer feeding the IF/ID register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               if_instr_out,
  output logic [31:0]               if_pc_out,
  output logic                      if_valid_out
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic        kill;
  logic        kill_n;
  logic        reqv_n;
  logic [31:0] addr_n;
  logic        valid_n;
  logic [31:0] instr_n;
  logic [31:0] pco_n;
  logic [31:0] rpc;
  logic [31:0] tgt;

  assign rpc = redirect_pc & ~32'h3;
  assign tgt = redirect_valid ? rpc : pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      pc                  <= RESET_PC;
      kill                <= 1'b0;
      imem.imem_req_valid <= 1'b0;
      imem.imem_req_addr  <= RESET_PC;
      if_valid_out        <= 1'b0;
      if_instr_out        <= NOP_INSTR;
      if_pc_out           <= RESET_PC;
    end else begin
      state               <= state_n;
      pc                  <= pc_n;
      kill                <= kill_n;
      imem.imem_req_valid <= reqv_n;
      imem.imem_req_addr  <= addr_n;
      if_valid_out        <= valid_n;
      if_instr_out        <= instr_n;
      if_pc_out           <= pco_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    reqv_n  = imem.imem_req_valid;
    addr_n  = imem.imem_req_addr;
    valid_n = if_valid_out;
    instr_n = if_instr_out;
    pco_n   = if_pc_out;

    if (if_valid_out && !stall) begin
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
    end

    unique case (state)
      IDLE: begin
        // Issue only if the buffer will be empty at the next edge.
        if (!(if_valid_out && stall)) begin
          state_n = REQ;
          reqv_n  = 1'b1;
          addr_n  = tgt;
          pc_n    = tgt + 32'd4;
          kill_n  = 1'b0;
        end else if (redirect_valid) begin
          pc_n = rpc;
        end
      end
      REQ: begin
        if (imem.imem_req_ready) begin
          state_n = WAIT;
          reqv_n  = 1'b0;
        end
        if (redirect_valid) begin
          pc_n   = rpc;
          kill_n = 1'b1;
        end
      end
      WAIT: begin
        if (imem.imem_resp_valid) begin
          state_n = IDLE;
          if (!kill && !redirect_valid) begin
            valid_n = 1'b1;
            instr_n = imem.imem_resp_data;
            pco_n   = imem.imem_req_addr;
          end
        end
        if (redirect_valid) begin
          pc_n   = rpc;
          kill_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (redirect_valid) begin
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple imem model
// and request/delivery scoreboards.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr_out;
  logic [31:0] if_pc_out;
  logic        if_valid_out;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (RPC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus.master),
    .if_instr_out   (if_instr_out),
    .if_pc_out      (if_pc_out),
    .if_valid_out   (if_valid_out)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_out[$];
  int          resp_delay = 0;
  logic        prev_v = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  // Memory: one response per accepted request, resp_delay extra cycles.
  always @(posedge clk) begin
    bus.imem_resp_valid <= 1'b0;
    bus.imem_resp_data  <= 32'h0;
    if (pend) begin
      if (cnt == 0) begin
        bus.imem_resp_valid <= 1'b1;
        bus.imem_resp_data  <= memf(paddr);
        pend                <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      if (resp_delay == 0) begin
        bus.imem_resp_valid <= 1'b1;
        bus.imem_resp_data  <= memf(bus.imem_req_addr);
      end else begin
        pend  <= 1'b1;
        cnt   <= resp_delay - 1;
        paddr <= bus.imem_req_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] e;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      n_assert++;
      assert (exp_req.size() != 0) else begin
        n_fail++;
        $error("FAIL req_q observed=%h expected=no request",
               bus.imem_req_addr);
      end
      if (exp_req.size() != 0) begin
        e = exp_req.pop_front();
        chk("req_addr", bus.imem_req_addr, e);
      end
    end
    @(posedge clk);
    #1;
    if (if_valid_out && !prev_v) begin
      n_assert++;
      assert (exp_out.size() != 0) else begin
        n_fail++;
        $error("FAIL out_q observed=%h expected=no delivery", if_pc_out);
      end
      if (exp_out.size() != 0) begin
        e = exp_out.pop_front();
        chk("out_pc", if_pc_out, e);
        chk("out_instr", if_instr_out, memf(e));
      end
    end
    prev_v = if_valid_out;
  endtask

  task automatic wait_req(input logic [31:0] a, input int max);
    int n = 0;
    while (!(bus.imem_req_valid && bus.imem_req_addr === a) && n < max) begin
      tick();
      n++;
    end
    chk("wait_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("wait_req_addr", bus.imem_req_addr, a);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_out.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain", exp_out.size(), 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_reqv", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_addr", bus.imem_req_addr, RPC);
    chk("rst_valid", {31'b0, if_valid_out}, 32'd0);
    chk("rst_instr", if_instr_out, NOP);
    chk("rst_pc", if_pc_out, RPC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    stall              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'h0;
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_reset();
    end

    // Fetch 0x0 and hold it under stall.
    exp_req.push_back(32'h0);
    exp_out.push_back(32'h0);
    stall = 1'b1;
    reset = 1'b1;
    wait_drain(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'b0, if_valid_out}, 32'd1);
      chk("stall_pc", if_pc_out, 32'h0);
      chk("stall_instr", if_instr_out, memf(32'h0));
      chk("stall_reqv", {31'b0, bus.imem_req_valid}, 32'd0);
    end
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_out.push_back(32'h4);
    stall = 1'b0;
    tick();
    chk("unstall_reqv", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("unstall_addr", bus.imem_req_addr, 32'h4);

    // Redirect while waiting on 0x8; its late response must be dropped.
    wait_req(32'h8, 20);
    resp_delay = 2;
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_out.push_back(32'h100);
    exp_out.push_back(32'h104);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    resp_delay     = 0;
    chk("redir_valid", {31'b0, if_valid_out}, 32'd0);
    chk("redir_reqv", {31'b0, bus.imem_req_valid}, 32'd0);

    // Redirect during a back-pressured request.
    exp_req.push_back(32'h108);
    exp_req.push_back(32'h200);
    exp_out.push_back(32'h200);
    wait_req(32'h108, 40);
    bus.imem_req_ready = 1'b0;
    redirect_valid     = 1'b1;
    redirect_pc        = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("bp_valid", {31'b0, if_valid_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_reqv", {31'b0, bus.imem_req_valid}, 32'd1);
      chk("bp_addr", bus.imem_req_addr, 32'h108);
      tick();
    end
    chk("bp_addr_last", bus.imem_req_addr, 32'h108);
    bus.imem_req_ready = 1'b1;
    tick();

    // Reset while waiting; the response lands during reset.
    exp_req.push_back(32'h204);
    wait_req(32'h204, 30);
    resp_delay = 2;
    tick();
    resp_delay = 0;
    reset      = 1'b0;
    #1;
    chk_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_reset();
    end
    exp_req.push_back(RPC);
    exp_out.push_back(RPC);
    reset = 1'b1;
    wait_drain(20);

    // Redirect to the top of memory; PC wraps to zero.
    exp_req.push_back(32'h4);
    wait_req(32'h4, 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    exp_out.push_back(32'hFFFF_FFFC);
    exp_out.push_back(32'h0);
    tick();
    redirect_valid = 1'b0;
    wait_drain(40);
    stall = 1'b1;
    repeat (4) tick();
    chk("end_req_q", exp_req.size(), 32'd0);
    chk("end_valid", {31'b0, if_valid_out}, 32'd1);
    chk("end_pc", if_pc_out, 32'h0);
    chk("end_reqv", {31'b0, bus.imem_req_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
